// File: rtl/core_pkg.sv
// Shared RV32I opcode and sequencer state encodings (instruction_mux, decoder, sequencer).
// Latency: n/a, constants only.  Backpressure: n/a.
package core_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } seqState_e;

endpackage

// File: rtl/core_sequencer_opcode_classifier.sv
// Classifies a 7-bit RV32I opcode into the control classes the sequencer branches on.
// Latency: combinational.  Backpressure: none.
module opcode_classifier
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_legal,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       writes_rd
);

    always_comb begin
        is_legal  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_R, OPC_I, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                is_legal  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                is_legal  = 1'b1;
                is_load   = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                is_legal = 1'b1;
                is_store = 1'b1;
            end
            OPC_BRANCH: begin
                is_legal  = 1'b1;
                is_branch = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: fetch into IR, DECODE/EXEC/MEM/WB, RF/PC strobes, dmem requests.
// Latency: 3-5 cycles per instruction plus memory waits.  Backpressure: req held until ack, stalls in FETCH/MEM.
// Optional SEQ_PERF_CNT_EN adds cycle and retired-instruction counters; otherwise those ports read 0.
module core_sequencer
    import core_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             iCLK,
    input  logic             iRST,
    output logic             oIMEM_REQ,
    input  logic             iIMEM_ACK,
    input  logic [31:0]      iINSTR,
    output logic [31:0]      oIR,
    output logic [6:0]       oOPCODE,
    output logic             oDMEM_REQ,
    output logic             oDMEM_WE,
    input  logic             iDMEM_ACK,
    output logic             oRF_WE,
    output logic             oPC_WE,
    output logic             oILLEGAL,
    output logic [2:0]       oSTATE,
    output logic [CNT_W-1:0] oCYCLE_CNT,
    output logic [CNT_W-1:0] oINSTRET_CNT
);

    // Held as raw bits so the unused codes 6/7 stay representable and recoverable.
    logic [2:0]  state;
    logic [2:0]  stateNext;
    logic [31:0] ir;
    logic        illegal;

    logic        isLegal;
    logic        isLoad;
    logic        isStore;
    logic        isBranch;
    logic        writesRd;

    logic        imemReq;
    logic        dmemReq;
    logic        dmemWe;
    logic        rfWe;
    logic        pcWe;

    opcode_classifier uClassifier (
        .opcode    (ir[6:0]),
        .is_legal  (isLegal),
        .is_load   (isLoad),
        .is_store  (isStore),
        .is_branch (isBranch),
        .writes_rd (writesRd)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= ST_FETCH;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_FETCH: begin
                if (iIMEM_ACK) begin
                    stateNext = ST_DECODE;
                end
            end
            ST_DECODE: stateNext = isLegal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                if (isLoad || isStore) begin
                    stateNext = ST_MEM;
                end else if (isBranch) begin
                    stateNext = ST_FETCH;
                end else begin
                    stateNext = ST_WB;
                end
            end
            ST_MEM: begin
                if (iDMEM_ACK) begin
                    stateNext = isStore ? ST_FETCH : ST_WB;
                end
            end
            ST_WB:   stateNext = ST_FETCH;
            ST_TRAP: stateNext = ST_TRAP;
            default: stateNext = ST_FETCH;
        endcase
    end

    always_comb begin
        imemReq = 1'b0;
        dmemReq = 1'b0;
        dmemWe  = 1'b0;
        rfWe    = 1'b0;
        pcWe    = 1'b0;
        case (state)
            ST_FETCH: imemReq = 1'b1;
            ST_EXEC:  pcWe    = isBranch;
            ST_MEM: begin
                dmemReq = 1'b1;
                dmemWe  = isStore;
                pcWe    = isStore && iDMEM_ACK;
            end
            ST_WB: begin
                rfWe = writesRd && (ir[11:7] != 5'd0);
                pcWe = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset forces FETCH, so the fetch request must be masked while reset is held.
    assign oIMEM_REQ = imemReq && !iRST;
    assign oDMEM_REQ = dmemReq;
    assign oDMEM_WE  = dmemWe;
    assign oRF_WE    = rfWe;
    assign oPC_WE    = pcWe;
    assign oSTATE    = state;
    assign oIR       = ir;
    assign oOPCODE   = ir[6:0];
    assign oILLEGAL  = illegal;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            ir <= '0;
        end else if (state == ST_FETCH && iIMEM_ACK) begin
            ir <= iINSTR;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            illegal <= 1'b0;
        end else if (state == ST_DECODE && !isLegal) begin
            illegal <= 1'b1;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] instretCnt;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cycleCnt   <= '0;
            instretCnt <= '0;
        end else begin
            cycleCnt <= cycleCnt + CNT_ONE;
            if (pcWe) begin
                instretCnt <= instretCnt + CNT_ONE;
            end
        end
    end

    assign oCYCLE_CNT   = cycleCnt;
    assign oINSTRET_CNT = instretCnt;
`else
    assign oCYCLE_CNT   = '0;
    assign oINSTRET_CNT = '0;
`endif

endmodule
